// File: rtl/fft_step0_ctrl.sv
// Sequencer for the first radix-2 SDF stage: fill / butterfly / drain control of the
// HALF-deep delay line, plus a tagged output stream {valid, sel, idx, done} for the next stage.
module fft_step0_ctrl #(
  parameter int unsigned N_BLK   = 32,
  parameter int unsigned OUT_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic                     sr_shift_en,
  output logic                     sr_sel,
  output logic                     bf_en,
  output logic                     dout_valid,
  output logic                     dout_sel,
  output logic [$clog2(N_BLK)-1:0] dout_idx,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int unsigned HALF  = N_BLK / 2;
  localparam int unsigned IDX_W = $clog2(N_BLK);
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cnt_last;

  logic               sched_vld, sched_sel, sched_done;
  logic [IDX_W-1:0]   sched_idx;

  logic [OUT_LAT-1:0]            vld_q, vld_d;
  logic [OUT_LAT-1:0]            sel_q, sel_d;
  logic [OUT_LAT-1:0]            done_q, done_d;
  logic [OUT_LAT-1:0][IDX_W-1:0] idx_q, idx_d;

  assign cnt_last = (cnt_q == CNT_W'(HALF - 1));

  // State, block counter and output tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      sel_q   <= '0;
      done_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
    end
  end

  // Next state, Mealy controls and output scheduling
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_ready   = 1'b0;
    sr_shift_en = 1'b0;
    sr_sel      = 1'b0;
    bf_en       = 1'b0;
    frame_start = 1'b0;
    sched_vld   = 1'b0;
    sched_sel   = 1'b0;
    sched_done  = 1'b0;
    sched_idx   = '0;

    unique case (state_q)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          sr_shift_en = 1'b1;
          frame_start = 1'b1;
          cnt_d       = CNT_W'(1);
          state_d     = FILL;
        end
      end
      FILL: begin
        din_ready = 1'b1;
        if (din_valid) begin
          sr_shift_en = 1'b1;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = BFLY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      BFLY: begin
        din_ready = 1'b1;
        if (din_valid) begin
          bf_en       = 1'b1;
          sr_shift_en = 1'b1;
          sr_sel      = 1'b1;
          sched_vld   = 1'b1;
          sched_idx   = IDX_W'(cnt_q);
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        sr_shift_en = 1'b1;
        sched_vld   = 1'b1;
        sched_sel   = 1'b1;
        sched_idx   = IDX_W'(HALF) + IDX_W'(cnt_q);
        if (cnt_last) begin
          cnt_d      = '0;
          state_d    = IDLE;
          sched_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // No handshakes or shifts while reset is held
    if (rst) begin
      din_ready   = 1'b0;
      sr_shift_en = 1'b0;
      sr_sel      = 1'b0;
      bf_en       = 1'b0;
      frame_start = 1'b0;
    end
  end

  // Output tag delay line: stage 0 takes the scheduled tag, the last stage drives the ports
  always_comb begin
    vld_d     = vld_q;
    sel_d     = sel_q;
    done_d    = done_q;
    idx_d     = idx_q;
    vld_d[0]  = sched_vld;
    sel_d[0]  = sched_sel;
    done_d[0] = sched_done;
    idx_d[0]  = sched_idx;
    for (int i = 1; i < int'(OUT_LAT); i++) begin
      vld_d[i]  = vld_q[i-1];
      sel_d[i]  = sel_q[i-1];
      done_d[i] = done_q[i-1];
      idx_d[i]  = idx_q[i-1];
    end
  end

  assign dout_valid = vld_q[OUT_LAT-1];
  assign dout_sel   = sel_q[OUT_LAT-1];
  assign dout_idx   = idx_q[OUT_LAT-1];
  assign frame_done = done_q[OUT_LAT-1];
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fft_step0_ctrl.sv
// Directed bench for fft_step0_ctrl: default (32,1) instance plus a (4,3) instance for the sweep.
module tb_fft_step0_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, din_valid, din_valid_b;
  logic       a_din_ready, a_sr_shift_en, a_sr_sel, a_bf_en, a_dout_valid, a_dout_sel;
  logic       a_frame_start, a_frame_done, a_busy;
  logic [4:0] a_dout_idx;
  logic       b_din_ready, b_sr_shift_en, b_sr_sel, b_bf_en, b_dout_valid, b_dout_sel;
  logic       b_frame_start, b_frame_done, b_busy;
  logic [1:0] b_dout_idx;
  logic [8:0] a_vec, b_vec;

  int checks = 0;
  int errors = 0;

  fft_step0_ctrl #(.N_BLK(32), .OUT_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(a_din_ready),
    .sr_shift_en(a_sr_shift_en), .sr_sel(a_sr_sel), .bf_en(a_bf_en),
    .dout_valid(a_dout_valid), .dout_sel(a_dout_sel), .dout_idx(a_dout_idx),
    .frame_start(a_frame_start), .frame_done(a_frame_done), .busy(a_busy)
  );

  fft_step0_ctrl #(.N_BLK(4), .OUT_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst), .din_valid(din_valid_b), .din_ready(b_din_ready),
    .sr_shift_en(b_sr_shift_en), .sr_sel(b_sr_sel), .bf_en(b_bf_en),
    .dout_valid(b_dout_valid), .dout_sel(b_dout_sel), .dout_idx(b_dout_idx),
    .frame_start(b_frame_start), .frame_done(b_frame_done), .busy(b_busy)
  );

  // Bit order: ready, shift, sr_sel, bf_en, frame_start, busy, dout_valid, dout_sel, frame_done
  assign a_vec = {a_din_ready, a_sr_shift_en, a_sr_sel, a_bf_en, a_frame_start,
                  a_busy, a_dout_valid, a_dout_sel, a_frame_done};
  assign b_vec = {b_din_ready, b_sr_shift_en, b_sr_sel, b_bf_en, b_frame_start,
                  b_busy, b_dout_valid, b_dout_sel, b_frame_done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [8:0] obs, input logic [8:0] exp,
                       input logic [31:0] obs_idx, input int exp_idx);
    chk(tag, 32'(obs), 32'(exp));
    if (exp[2]) chk({tag, " idx"}, obs_idx, 32'(exp_idx));
  endtask

  // Expected controls for one N_BLK=32 frame with din_valid high in cycles 0..31 only
  function automatic logic [8:0] b2b(input int k);
    return {(k < 32) || (k >= 48), k < 48, (k >= 16) && (k < 32), (k >= 16) && (k < 32),
            k == 0, (k >= 1) && (k < 48), (k >= 17) && (k <= 48), (k >= 33) && (k <= 48),
            k == 48};
  endfunction

  initial begin
    logic [8:0] e;

    // Reset held with din_valid asserted
    rst = 1'b1; din_valid = 1'b1; din_valid_b = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_v($sformatf("reset a c%0d", i), a_vec, 9'h000, 32'(a_dout_idx), 0);
      chk($sformatf("reset a idx c%0d", i), 32'(a_dout_idx), 32'd0);
      chk($sformatf("reset b c%0d", i), 32'(b_vec), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; din_valid = 1'b0; din_valid_b = 1'b0;
    @(negedge clk);
    chk("post-reset a", 32'(a_vec), 32'h100);
    chk("post-reset b", 32'(b_vec), 32'h100);
    @(posedge clk); #1;

    // Back-to-back frame
    for (int k = 0; k < 50; k++) begin
      din_valid = (k < 32);
      @(negedge clk);
      chk_v($sformatf("b2b c%0d", k), a_vec, b2b(k), 32'(a_dout_idx), k - 17);
      @(posedge clk); #1;
    end

    // Gapped input, accepts on even cycles only
    for (int g = 0; g < 81; g++) begin
      logic acc, add, sub;
      din_valid = (g < 64) && (g % 2 == 0);
      acc = (g < 63) && (g % 2 == 0);
      add = (g >= 33) && (g <= 63) && (g % 2 == 1);
      sub = (g >= 64) && (g <= 79);
      e = {(g < 63) || (g >= 79), acc || ((g >= 63) && (g < 79)),
           acc && (g >= 32), acc && (g >= 32), g == 0, (g >= 1) && (g < 79),
           add || sub, sub, g == 79};
      @(negedge clk);
      chk_v($sformatf("gap c%0d", g), a_vec, e, 32'(a_dout_idx), sub ? g - 48 : (g - 33) / 2);
      @(posedge clk); #1;
    end

    // din_valid held through DRAIN and into the next frame
    for (int k = 0; k < 53; k++) begin
      din_valid = 1'b1;
      e = {(k < 32) || (k >= 48), 1'b1, (k >= 16) && (k < 32), (k >= 16) && (k < 32),
           (k == 0) || (k == 48), ((k >= 1) && (k < 48)) || (k >= 49),
           (k >= 17) && (k <= 48), (k >= 33) && (k <= 48), k == 48};
      @(negedge clk);
      chk_v($sformatf("held c%0d", k), a_vec, e, 32'(a_dout_idx), k - 17);
      @(posedge clk); #1;
    end

    // Abort the frame in FILL with a short reset
    rst = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort reset a", 32'(a_vec), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-BFLY at cycle 20, fresh frame from cycle 25
    for (int k = 0; k < 76; k++) begin
      rst       = (k == 20);
      din_valid = (k < 20) || ((k >= 25) && (k < 57));
      if (k < 20)       e = b2b(k);
      else if (k == 20) e = b2b(20) & 9'h00F;
      else if (k < 25)  e = 9'h100;
      else              e = b2b(k - 25);
      @(negedge clk);
      chk_v($sformatf("midrst c%0d", k), a_vec, e, 32'(a_dout_idx), (k <= 20) ? k - 17 : k - 42);
      @(posedge clk); #1;
    end
    rst = 1'b0; din_valid = 1'b0;

    // N_BLK=4, OUT_LAT=3 frame
    for (int k = 0; k < 11; k++) begin
      din_valid_b = (k < 4);
      e = {(k < 4) || (k >= 6), k < 6, (k == 2) || (k == 3), (k == 2) || (k == 3), k == 0,
           (k >= 1) && (k < 6), (k >= 5) && (k <= 8), (k == 7) || (k == 8), k == 8};
      @(negedge clk);
      chk_v($sformatf("sweep c%0d", k), b_vec, e, 32'(b_dout_idx), k - 5);
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
